// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the fetch stage.
// Arbitrates trap / branch / eret / jump redirects, parks a redirect that
// arrives while fetch cannot advance, kills the fetches that follow a
// redirect, and provides halt/resume plus the saved exception PC.

module pc_sequencer #(
   parameter int              PC_W         = 27,
   parameter logic [PC_W-1:0] RESET_VEC    = '0,
   parameter int              FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fe_ready,
   input  logic            id_stall,
   input  logic            trap_req,
   input  logic [PC_W-1:0] trap_vec,
   input  logic [PC_W-1:0] trap_pc,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            eret_valid,
   input  logic            jmp_valid,
   input  logic [PC_W-1:0] jmp_target,
   input  logic            halt_req,
   output logic [PC_W-1:0] npc,
   output logic            npc_enn,
   output logic            n_stall,
   output logic            flush,
   output logic            trap_ack,
   output logic [PC_W-1:0] epc,
   output logic            halted
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      HALT  = 2'd3
   } state_t;

   // Priority numbers: lower value wins
   localparam logic [1:0] PRIO_TRAP = 2'd0;
   localparam logic [1:0] PRIO_BR   = 2'd1;
   localparam logic [1:0] PRIO_ERET = 2'd2;
   localparam logic [1:0] PRIO_JMP  = 2'd3;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

   state_t            state;
   state_t            next_state;
   logic [2:0]        flush_cnt;
   logic [2:0]        flush_cnt_next;

   logic              pend_valid;
   logic [1:0]        pend_prio;
   logic [PC_W-1:0]   pend_target;
   logic [PC_W-1:0]   pend_tpc;
   logic [PC_W-1:0]   epc_q;

   logic              in_valid;
   logic [1:0]        in_prio;
   logic [PC_W-1:0]   in_target;

   logic              sel_valid;
   logic              use_pend;
   logic [1:0]        sel_prio;
   logic [PC_W-1:0]   sel_target;
   logic [PC_W-1:0]   sel_tpc;
   logic [PC_W-1:0]   sel_aligned;

   logic              adv;
   logic              apply_redir;
   logic              latch_redir;
   logic              is_trap;

   logic [PC_W-1:0]   npc_c;
   logic              npc_enn_c;
   logic              n_stall_c;
   logic              flush_c;
   logic              trap_ack_c;

   // Fixed-priority pick among the redirect inputs asserted this cycle
   always_comb begin
      in_valid  = 1'b0;
      in_prio   = PRIO_JMP;
      in_target = '0;
      if (trap_req) begin
         in_valid  = 1'b1;
         in_prio   = PRIO_TRAP;
         in_target = trap_vec;
      end else if (br_taken) begin
         in_valid  = 1'b1;
         in_prio   = PRIO_BR;
         in_target = br_target;
      end else if (eret_valid) begin
         in_valid  = 1'b1;
         in_prio   = PRIO_ERET;
         in_target = epc_q;
      end else if (jmp_valid) begin
         in_valid  = 1'b1;
         in_prio   = PRIO_JMP;
         in_target = jmp_target;
      end
   end

   // Pending wins only if strictly higher priority; on a tie the new request wins
   always_comb begin
      use_pend   = pend_valid && (!in_valid || (pend_prio < in_prio));
      sel_valid  = in_valid || pend_valid;
      sel_prio   = in_prio;
      sel_target = in_target;
      sel_tpc    = trap_pc;
      if (use_pend) begin
         sel_prio   = pend_prio;
         sel_target = pend_target;
         sel_tpc    = pend_tpc;
      end
   end

   assign sel_aligned = {sel_target[PC_W-1:2], 2'b00};
   assign is_trap     = sel_valid && (sel_prio == PRIO_TRAP);

   // Next-state and output decode for the sequencer FSM
   always_comb begin
      next_state     = state;
      flush_cnt_next = flush_cnt;
      adv            = 1'b0;
      apply_redir    = 1'b0;
      latch_redir    = 1'b0;
      npc_c          = RESET_VEC;
      npc_enn_c      = 1'b0;
      n_stall_c      = 1'b0;
      flush_c        = 1'b0;
      trap_ack_c     = 1'b0;

      case (state)
         BOOT: begin
            npc_c       = RESET_VEC;
            npc_enn_c   = 1'b1;
            n_stall_c   = 1'b1;
            latch_redir = sel_valid;
            next_state  = RUN;
         end

         RUN: begin
            adv = fe_ready && !id_stall;
            if (sel_valid) begin
               if (adv) begin
                  apply_redir = 1'b1;
               end else begin
                  latch_redir = 1'b1;
               end
            end else if (halt_req) begin
               next_state = HALT;
            end else begin
               n_stall_c = adv;
            end
         end

         FLUSH: begin
            adv     = fe_ready;
            flush_c = 1'b1;
            if (sel_valid) begin
               if (adv) begin
                  apply_redir = 1'b1;
               end else begin
                  latch_redir = 1'b1;
               end
            end else if (adv) begin
               n_stall_c      = 1'b1;
               flush_cnt_next = flush_cnt - 3'd1;
               if (flush_cnt <= 3'd1) begin
                  next_state = RUN;
               end
            end
         end

         HALT: begin
            adv = fe_ready;
            if (is_trap && adv) begin
               apply_redir = 1'b1;
            end else begin
               latch_redir = sel_valid;
               if (!halt_req) begin
                  next_state = RUN;
               end
            end
         end

         default: begin
            next_state = BOOT;
         end
      endcase

      if (apply_redir) begin
         npc_c          = sel_aligned;
         npc_enn_c      = 1'b1;
         n_stall_c      = 1'b1;
         trap_ack_c     = is_trap;
         flush_cnt_next = FLUSH_INIT;
         next_state     = FLUSH;
      end
   end

   // State, flush counter, pending redirect and saved exception PC
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= BOOT;
         flush_cnt   <= '0;
         pend_valid  <= 1'b0;
         pend_prio   <= PRIO_JMP;
         pend_target <= '0;
         pend_tpc    <= '0;
         epc_q       <= '0;
      end else begin
         state     <= next_state;
         flush_cnt <= flush_cnt_next;
         if (apply_redir) begin
            pend_valid <= 1'b0;
            if (is_trap) begin
               epc_q <= sel_tpc;
            end
         end else if (latch_redir) begin
            pend_valid  <= 1'b1;
            pend_prio   <= sel_prio;
            pend_target <= sel_target;
            pend_tpc    <= sel_tpc;
         end
      end
   end

   // Reset forces the PC-register controls immediately, independent of the clock
   always_comb begin
      if (!rst) begin
         npc      = RESET_VEC;
         npc_enn  = 1'b0;
         n_stall  = 1'b0;
         flush    = 1'b0;
         trap_ack = 1'b0;
         halted   = 1'b0;
      end else begin
         npc      = npc_c;
         npc_enn  = npc_enn_c;
         n_stall  = n_stall_c;
         flush    = flush_c;
         trap_ack = trap_ack_c;
         halted   = (state == HALT);
      end
   end

   assign epc = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
// Expected redirect targets go into a queue when the redirect is driven and
// are popped whenever the DUT asserts npc_enn.

module tb_pc_sequencer;

   localparam int PC_W = 27;

   logic            clk;
   logic            rst;
   logic            fe_ready;
   logic            id_stall;
   logic            trap_req;
   logic [PC_W-1:0] trap_vec;
   logic [PC_W-1:0] trap_pc;
   logic            br_taken;
   logic [PC_W-1:0] br_target;
   logic            eret_valid;
   logic            jmp_valid;
   logic [PC_W-1:0] jmp_target;
   logic            halt_req;
   logic [PC_W-1:0] npc;
   logic            npc_enn;
   logic            n_stall;
   logic            flush;
   logic            trap_ack;
   logic [PC_W-1:0] epc;
   logic            halted;

   logic [PC_W-1:0] exp_q[$];
   logic [PC_W-1:0] exp_npc;
   int              tests_run;
   int              tests_failed;

   pc_sequencer #(
      .PC_W(PC_W),
      .RESET_VEC('0),
      .FLUSH_CYCLES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fe_ready(fe_ready),
      .id_stall(id_stall),
      .trap_req(trap_req),
      .trap_vec(trap_vec),
      .trap_pc(trap_pc),
      .br_taken(br_taken),
      .br_target(br_target),
      .eret_valid(eret_valid),
      .jmp_valid(jmp_valid),
      .jmp_target(jmp_target),
      .halt_req(halt_req),
      .npc(npc),
      .npc_enn(npc_enn),
      .n_stall(n_stall),
      .flush(flush),
      .trap_ack(trap_ack),
      .epc(epc),
      .halted(halted)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a stuck run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      fe_ready   = 1'b1;
      id_stall   = 1'b0;
      trap_req   = 1'b0;
      trap_vec   = '0;
      trap_pc    = '0;
      br_taken   = 1'b0;
      br_target  = '0;
      eret_valid = 1'b0;
      jmp_valid  = 1'b0;
      jmp_target = '0;
      halt_req   = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests_run++;
      if (npc !== '0 || npc_enn !== 1'b0 || n_stall !== 1'b0 || flush !== 1'b0 ||
          trap_ack !== 1'b0 || halted !== 1'b0 || epc !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: npc=%0h enn=%0b nst=%0b fl=%0b ack=%0b h=%0b epc=%0h, want all 0",
                  npc, npc_enn, n_stall, flush, trap_ack, halted, epc);
      end
      step();
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (npc_enn !== 1'b1 || npc !== '0 || n_stall !== 1'b1 || flush !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL boot_load: npc=%0h enn=%0b nst=%0b fl=%0b, want 0/1/1/0",
                  npc, npc_enn, n_stall, flush);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         @(negedge clk);
         tests_run++;
         if (npc_enn !== 1'b0 || n_stall !== 1'b1 || flush !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL run_seq%0d: enn=%0b nst=%0b fl=%0b, want 0/1/0",
                     i, npc_enn, n_stall, flush);
         end
      end
      step();
   endtask

   task automatic test_branch();
      br_taken  = 1'b1;
      br_target = 27'h100;
      exp_q.push_back(27'h100);
      @(negedge clk);
      tests_run++;
      if (npc_enn !== 1'b1 || flush !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL br_apply: enn=%0b fl=%0b, want 1/0", npc_enn, flush);
      end
      if (npc_enn === 1'b1) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL br_sb: unexpected redirect npc=%0h", npc);
         end else begin
            exp_npc = exp_q.pop_front();
            if (npc !== exp_npc) begin
               tests_failed++;
               $display("[TB] FAIL br_npc: got %0h want %0h", npc, exp_npc);
            end
         end
      end
      step();
      br_taken = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         tests_run++;
         if (flush !== 1'b1 || npc_enn !== 1'b0 || n_stall !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL br_flush%0d: fl=%0b enn=%0b nst=%0b, want 1/0/1",
                     i, flush, npc_enn, n_stall);
         end
         step();
      end
      @(negedge clk);
      tests_run++;
      if (flush !== 1'b0 || n_stall !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL br_back_run: fl=%0b nst=%0b, want 0/1", flush, n_stall);
      end
      step();
   endtask

   task automatic test_pending();
      id_stall   = 1'b1;
      jmp_valid  = 1'b1;
      jmp_target = 27'h40;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            br_taken  = 1'b1;
            br_target = 27'h80;
            exp_q.push_back(27'h80);
         end else begin
            br_taken = 1'b0;
         end
         @(negedge clk);
         tests_run++;
         if (n_stall !== 1'b0 || npc_enn !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pend_hold%0d: nst=%0b enn=%0b, want 0/0", i, n_stall, npc_enn);
         end
         step();
      end
      id_stall  = 1'b0;
      jmp_valid = 1'b0;
      br_taken  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 0) begin
            tests_run++;
            if (npc_enn !== 1'b1) begin
               tests_failed++;
               $display("[TB] FAIL pend_apply: enn=%0b want 1", npc_enn);
            end
         end
         if (npc_enn === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("[TB] FAIL pend_sb: unexpected redirect npc=%0h", npc);
            end else begin
               exp_npc = exp_q.pop_front();
               if (npc !== exp_npc) begin
                  tests_failed++;
                  $display("[TB] FAIL pend_npc: got %0h want %0h", npc, exp_npc);
               end
            end
         end
         step();
      end
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL pend_drain: %0d redirects not issued, want 0", exp_q.size());
      end
   endtask

   task automatic test_trap_eret();
      trap_req  = 1'b1;
      trap_vec  = 27'h200;
      trap_pc   = 27'h1C;
      br_taken  = 1'b1;
      br_target = 27'h300;
      exp_q.push_back(27'h200);
      @(negedge clk);
      tests_run++;
      if (npc_enn !== 1'b1 || trap_ack !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL trap_apply: enn=%0b ack=%0b, want 1/1", npc_enn, trap_ack);
      end
      if (npc_enn === 1'b1) begin
         tests_run++;
         exp_npc = exp_q.pop_front();
         if (npc !== exp_npc) begin
            tests_failed++;
            $display("[TB] FAIL trap_npc: got %0h want %0h", npc, exp_npc);
         end
      end
      step();
      trap_req = 1'b0;
      br_taken = 1'b0;
      @(negedge clk);
      tests_run++;
      if (epc !== 27'h1C || trap_ack !== 1'b0 || flush !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL trap_epc: epc=%0h ack=%0b fl=%0b, want 1c/0/1", epc, trap_ack, flush);
      end
      step();
      step();
      eret_valid = 1'b1;
      exp_q.push_back(27'h1C);
      @(negedge clk);
      tests_run++;
      if (npc_enn !== 1'b1 || trap_ack !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL eret_apply: enn=%0b ack=%0b, want 1/0", npc_enn, trap_ack);
      end
      if (npc_enn === 1'b1) begin
         tests_run++;
         exp_npc = exp_q.pop_front();
         if (npc !== exp_npc) begin
            tests_failed++;
            $display("[TB] FAIL eret_npc: got %0h want %0h", npc, exp_npc);
         end
      end
      step();
      eret_valid = 1'b0;
      step();
      step();
   endtask

   task automatic test_halt();
      halt_req = 1'b1;
      @(negedge clk);
      tests_run++;
      if (n_stall !== 1'b0 || halted !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL halt_enter: nst=%0b h=%0b, want 0/0", n_stall, halted);
      end
      step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if (halted !== 1'b1 || n_stall !== 1'b0 || npc_enn !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL halt_hold%0d: h=%0b nst=%0b enn=%0b, want 1/0/0",
                     i, halted, n_stall, npc_enn);
         end
         step();
      end
      trap_req = 1'b1;
      trap_vec = 27'h300;
      trap_pc  = 27'h44;
      exp_q.push_back(27'h300);
      @(negedge clk);
      tests_run++;
      if (npc_enn !== 1'b1 || n_stall !== 1'b1 || trap_ack !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL halt_trap: enn=%0b nst=%0b ack=%0b, want 1/1/1",
                  npc_enn, n_stall, trap_ack);
      end
      if (npc_enn === 1'b1) begin
         tests_run++;
         exp_npc = exp_q.pop_front();
         if (npc !== exp_npc) begin
            tests_failed++;
            $display("[TB] FAIL halt_trap_npc: got %0h want %0h", npc, exp_npc);
         end
      end
      step();
      trap_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (halted !== 1'b0 || flush !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL halt_left: h=%0b fl=%0b, want 0/1", halted, flush);
      end
      step();
      step();
      step();
      halt_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (halted !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL halt_reenter: h=%0b want 1", halted);
      end
      step();
      @(negedge clk);
      tests_run++;
      if (halted !== 1'b0 || n_stall !== 1'b1 || npc_enn !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL halt_resume: h=%0b nst=%0b enn=%0b, want 0/1/0",
                  halted, n_stall, npc_enn);
      end
      step();
   endtask

   task automatic test_reset_mid_flush();
      br_taken  = 1'b1;
      br_target = 27'h180;
      exp_q.push_back(27'h180);
      @(negedge clk);
      if (npc_enn === 1'b1) begin
         tests_run++;
         exp_npc = exp_q.pop_front();
         if (npc !== exp_npc) begin
            tests_failed++;
            $display("[TB] FAIL rstf_npc: got %0h want %0h", npc, exp_npc);
         end
      end
      step();
      br_taken = 1'b0;
      @(negedge clk);
      tests_run++;
      if (flush !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL rstf_in_flush: fl=%0b want 1", flush);
      end
      #1;
      rst = 1'b0;
      #1;
      tests_run++;
      if (flush !== 1'b0 || n_stall !== 1'b0 || npc_enn !== 1'b0 || epc !== '0 || npc !== '0) begin
         tests_failed++;
         $display("[TB] FAIL rstf_async: fl=%0b nst=%0b enn=%0b epc=%0h npc=%0h, want all 0",
                  flush, n_stall, npc_enn, epc, npc);
      end
      step();
      step();
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (npc_enn !== 1'b1 || npc !== '0 || flush !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL rstf_boot: enn=%0b npc=%0h fl=%0b, want 1/0/0", npc_enn, npc, flush);
      end
      step();
      @(negedge clk);
      tests_run++;
      if (npc_enn !== 1'b0 || flush !== 1'b0 || n_stall !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL rstf_run: enn=%0b fl=%0b nst=%0b, want 0/0/1", npc_enn, flush, n_stall);
      end
      step();
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL sb_final: %0d redirects outstanding, want 0", exp_q.size());
      end
   endtask

   // Test sequence
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      idle_inputs();
      #1;
      rst = 1'b0;
      test_reset();
      test_branch();
      test_pending();
      test_trap_eret();
      test_halt();
      test_reset_mid_flush();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
